// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle cpu: opcodes, register names, instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_WRO = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;

    localparam int AX = 0;
    localparam int BX = 1;
    localparam int CX = 2;
    localparam int DX = 3;

    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int RA_LSB  = 8;
    localparam int RB_LSB  = 4;
    localparam int RC_LSB  = 0;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the register-to-register instructions.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result is valid whenever operands are.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] y
);

    // Non-ALU opcodes pass a through; the decoder never writes it back for them.
    always_comb begin
        y = a;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MOV:  y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle register machine: register file, decode and registered output port.
// Latency: every instruction retires on the clk edge that samples it.
// Backpressure: none; one instruction is consumed on every rising clk edge.
module cpu
    import cpu_pkg::*;
#(
    parameter int N    = 16,
    parameter int REGN = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] inst,
    output logic [N-1:0] wr_addr,
    output logic [N-1:0] out
);

    localparam int RW = (REGN > 1) ? $clog2(REGN) : 1;

    logic [N-1:0]  regs [REGN];
    logic [3:0]    opcode;
    logic [RW-1:0] ra_idx;
    logic [RW-1:0] rb_idx;
    logic [RW-1:0] rc_idx;
    logic [N-1:0]  imm_ext;
    logic [N-1:0]  alu_y;

    logic          reg_we;
    logic [RW-1:0] reg_widx;
    logic [N-1:0]  reg_wdat;
    logic          out_we;

    // Upper field bits beyond the register index width are deliberately ignored.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst;

    assign opcode  = inst[OP_LSB +: FIELD_W];
    assign ra_idx  = inst[RA_LSB +: RW];
    assign rb_idx  = inst[RB_LSB +: RW];
    assign rc_idx  = inst[RC_LSB +: RW];
    assign imm_ext = {{(N-IMM_W){1'b0}}, inst[IMM_LSB +: IMM_W]};

    cpu_alu #(.N(N)) u_alu (
        .a  (regs[ra_idx]),
        .b  (regs[rb_idx]),
        .op (opcode),
        .y  (alu_y)
    );

    always_comb begin
        reg_we   = 1'b0;
        reg_widx = rc_idx;
        reg_wdat = alu_y;
        out_we   = 1'b0;
        case (opcode)
            OP_LDI: begin
                reg_we   = 1'b1;
                reg_widx = ra_idx;
                reg_wdat = imm_ext;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                reg_we = 1'b1;
            end
            OP_WRO: begin
                out_we = 1'b1;
            end
            default: begin
                reg_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REGN; i++) begin
                regs[i] <= '0;
            end
            out     <= '0;
            wr_addr <= '0;
        end else begin
            if (reg_we) begin
                regs[reg_widx] <= reg_wdat;
            end
            if (out_we) begin
                out     <= regs[ra_idx];
                wr_addr <= imm_ext;
            end
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Randomized bench for cpu against an instruction-level reference model, plus directed programs.
module tb_cpu;

    localparam int N    = 16;
    localparam int REGN = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] inst;
    logic [N-1:0] wr_addr;
    logic [N-1:0] out;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    logic [N-1:0] m_reg [REGN];
    logic [N-1:0] m_out;
    logic [N-1:0] m_addr;

    cpu #(.N(N), .REGN(REGN)) dut (
        .clk     (clk),
        .rst     (rst),
        .inst    (inst),
        .wr_addr (wr_addr),
        .out     (out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [15:0] f_ldi(input int rd, input int imm);
        logic [3:0] r;
        logic [7:0] v;
        r = rd[3:0];
        v = imm[7:0];
        return {4'h1, r, v};
    endfunction

    function automatic logic [15:0] f_wro(input int rd, input int addr);
        logic [3:0] r;
        logic [7:0] v;
        r = rd[3:0];
        v = addr[7:0];
        return {4'h4, r, v};
    endfunction

    function automatic logic [15:0] f_rrr(input int op, input int ra, input int rb, input int rc);
        logic [3:0] o, x, y, z;
        o = op[3:0];
        x = ra[3:0];
        y = rb[3:0];
        z = rc[3:0];
        return {o, x, y, z};
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect of each instruction, indices taken modulo REGN.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REGN; i++) m_reg[i] = '0;
            m_out  = '0;
            m_addr = '0;
        end else begin
            int op, a, b, c;
            logic [N-1:0] va, vb;
            op = int'(inst[15:12]);
            a  = int'(inst[11:8]) % REGN;
            b  = int'(inst[7:4]) % REGN;
            c  = int'(inst[3:0]) % REGN;
            va = m_reg[a];
            vb = m_reg[b];
            case (op)
                1: m_reg[a] = N'(inst[7:0]);
                2: m_reg[c] = va + vb;
                3: m_reg[c] = va - vb;
                4: begin m_out = va; m_addr = N'(inst[7:0]); end
                5: m_reg[c] = va & vb;
                6: m_reg[c] = va | vb;
                7: m_reg[c] = va ^ vb;
                8: m_reg[c] = va;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out", out, m_out);
            chk("cyc_wr_addr", wr_addr, m_addr);
        end
    end

    task automatic ex(input logic [15:0] i);
        @(negedge clk);
        inst = i;
        @(posedge clk);
        #1;
    endtask

    // Reset between edges with junk on inst, released on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst  = 0;
        inst = 16'($urandom);
        #1;
        chk("rst_out_immediate", out, 16'h0000);
        chk("rst_addr_immediate", wr_addr, 16'h0000);
        repeat (2) @(negedge clk);
        inst = 16'h0000;
        rst  = 1;
    endtask

    function automatic logic [15:0] rand_inst();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return f_wro($urandom_range(0, 15), $urandom_range(0, 255));
        if (r < 5) return f_ldi($urandom_range(0, 15), $urandom_range(0, 255));
        return 16'($urandom);
    endfunction

    initial begin
        rst  = 1;
        inst = '0;
        #1 rst = 0;
        #20;
        @(negedge clk);
        rst = 1;
        cmp_en = 1;

        // Load and output
        ex(f_ldi(0, 42));
        ex(f_wro(0, 0));
        ex(16'h0000);
        chk("load_out", out, 16'd42);
        chk("load_addr", wr_addr, 16'd0);
        checks++;
        if ($isunknown(out)) begin
            errors++;
            $display("FAIL load_out_x: got %h expected known value", out);
        end

        // Async reset mid-stream clears immediately, prior state is gone
        do_reset();
        ex(f_wro(0, 0));
        chk("after_rst_out", out, 16'd0);

        // Single add
        do_reset();
        ex(f_ldi(0, 20));
        ex(f_ldi(1, 3));
        ex(f_rrr(2, 0, 1, 2));
        ex(f_wro(2, 0));
        chk("add_out", out, 16'd23);

        // Accumulate with rc == ra
        do_reset();
        ex(f_ldi(0, 3));
        ex(f_ldi(1, 2));
        ex(f_rrr(2, 0, 1, 2));
        ex(f_rrr(2, 2, 1, 2));
        ex(f_rrr(2, 2, 1, 2));
        ex(f_wro(2, 0));
        chk("accum_out", out, 16'd9);

        // Subtract and wrap
        do_reset();
        ex(f_ldi(0, 19));
        ex(f_ldi(1, 3));
        ex(f_rrr(3, 0, 1, 2));
        ex(f_wro(2, 0));
        chk("sub_out", out, 16'd16);
        ex(f_rrr(3, 1, 0, 3));
        ex(f_wro(3, 5));
        chk("sub_wrap_out", out, 16'hFFF0);
        chk("sub_wrap_addr", wr_addr, 16'd5);

        // Logic op, then an illegal opcode behaves as NOP
        do_reset();
        ex(f_ldi(0, 8'hF0));
        ex(f_ldi(1, 8'h3C));
        ex(f_rrr(7, 0, 1, 2));
        ex(f_wro(2, 1));
        chk("xor_out", out, 16'h00CC);
        ex(16'hF012);
        ex(f_wro(2, 1));
        chk("op15_out", out, 16'h00CC);
        chk("op15_addr", wr_addr, 16'd1);

        // Upper field bits ignored: register 6 aliases CX, 7 aliases DX
        ex(f_ldi(7, 8'h5A));
        ex(f_wro(3, 9));
        chk("alias_out", out, 16'h005A);

        // Random programs with occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else ex(rand_inst());
        end

        @(negedge clk);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
